// File: rtl/haar_feature_classifier.sv
// Haar-feature classifier: issues up to NUM_POINTS integral-image corner reads,
// accumulates their signed weighted sum and compares it with an adjustable threshold.
module haar_feature_classifier #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 21,
    parameter int SCORE_WIDTH = 26,
    parameter int NUM_POINTS  = 8,
    parameter int CNT_WIDTH   = 4,
    parameter int RD_LATENCY  = 3,
    parameter int THR_INIT    = 0,
    parameter int THR_STEP    = 100,
    parameter int THR_MAX     = 288000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_POINTS*ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [NUM_POINTS*3-1:0]           cfg_weight,
    input  logic [CNT_WIDTH-1:0]              cfg_count,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic                              increment_threshold,
    input  logic                              decrement_threshold,
    input  logic                              detect_en,
    output logic [ADDR_WIDTH-1:0]             rd_addr,
    input  logic signed [DATA_WIDTH-1:0]      data_in,
    output logic                              busy,
    output logic                              detect_done,
    output logic                              detected_flag,
    output logic signed [SCORE_WIDTH-1:0]     score,
    output logic signed [SCORE_WIDTH-1:0]     threshold
);

    localparam int IDX_W  = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
    localparam int TAB_N  = 2 ** IDX_W;
    localparam int PROD_W = DATA_WIDTH + 3;
    localparam logic signed [SCORE_WIDTH:0] STEP_W = (SCORE_WIDTH + 1)'(THR_STEP);
    localparam logic signed [SCORE_WIDTH:0] MAX_W  = (SCORE_WIDTH + 1)'(THR_MAX);
    localparam logic signed [SCORE_WIDTH:0] MIN_W  = -MAX_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMPARE} state_t;

    state_t                          state_q, state_d;
    logic                            en_q;
    logic [NUM_POINTS*ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [NUM_POINTS*3-1:0]         cfg_weight_q, cfg_weight_d;
    logic [ADDR_WIDTH-1:0]           base_q, base_d;
    logic [CNT_WIDTH-1:0]            n_q, n_d, idx_q, idx_d, n_start;
    logic signed [SCORE_WIDTH-1:0]   acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]           rd_addr_q, rd_addr_d;
    logic                            rd_valid_q, rd_valid_d;
    logic signed [2:0]               rd_wt_q, rd_wt_d;
    logic [RD_LATENCY-1:0]           pipe_v_q, pipe_v_d;
    logic signed [2:0]               pipe_w_q [RD_LATENCY];
    logic signed [2:0]               pipe_w_d [RD_LATENCY];
    logic                            busy_q, busy_d, done_q, done_d, flag_q, flag_d;
    logic signed [SCORE_WIDTH-1:0]   score_q, score_d, thr_q, thr_d;
    logic signed [SCORE_WIDTH:0]     thr_up, thr_dn;
    logic signed [PROD_W-1:0]        prod;
    logic signed [SCORE_WIDTH-1:0]   prod_ext;
    logic                            start, others_in_flight;
    logic [ADDR_WIDTH-1:0]           off_tab [TAB_N];
    logic signed [2:0]               wt_tab [TAB_N];

    // Unpack the latched feature shape; padding entries are never selected.
    for (genvar k = 0; k < TAB_N; k++) begin : g_tab
        if (k < NUM_POINTS) begin : g_used
            assign off_tab[k] = cfg_addr_q[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign wt_tab[k]  = cfg_weight_q[k*3 +: 3];
        end else begin : g_pad
            assign off_tab[k] = '0;
            assign wt_tab[k]  = '0;
        end
    end

    assign start    = detect_en && !en_q && (state_q == IDLE);
    assign n_start  = (cfg_count > CNT_WIDTH'(NUM_POINTS)) ? CNT_WIDTH'(NUM_POINTS) : cfg_count;
    assign prod     = PROD_W'(data_in) * PROD_W'(pipe_w_q[RD_LATENCY-1]);
    assign prod_ext = SCORE_WIDTH'(prod);
    assign thr_up   = {thr_q[SCORE_WIDTH-1], thr_q} + STEP_W;
    assign thr_dn   = {thr_q[SCORE_WIDTH-1], thr_q} - STEP_W;

    always_comb begin
        others_in_flight = rd_valid_q;
        for (int j = 0; j < RD_LATENCY - 1; j++) begin
            others_in_flight = others_in_flight | pipe_v_q[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_start == '0)                   state_d = COMPARE;
                    else if (n_start == CNT_WIDTH'(1))   state_d = DRAIN;
                    else                                 state_d = ISSUE;
                end
            end
            ISSUE:   if (idx_q == n_q - CNT_WIDTH'(1)) state_d = DRAIN;
            DRAIN:   if (pipe_v_q[RD_LATENCY-1] && !others_in_flight) state_d = COMPARE;
            COMPARE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Point 0 is issued on the start edge itself so rd_addr carries it in the first busy cycle.
    always_comb begin
        cfg_addr_d   = cfg_addr_q;
        cfg_weight_d = cfg_weight_q;
        base_d       = base_q;
        n_d          = n_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        rd_addr_d    = '0;
        rd_valid_d   = 1'b0;
        rd_wt_d      = '0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        flag_d       = flag_q;
        score_d      = score_q;
        thr_d        = thr_q;
        pipe_v_d[0]  = rd_valid_q;
        pipe_w_d[0]  = rd_wt_q;
        for (int j = 1; j < RD_LATENCY; j++) begin
            pipe_v_d[j] = pipe_v_q[j-1];
            pipe_w_d[j] = pipe_w_q[j-1];
        end
        if (pipe_v_q[RD_LATENCY-1]) acc_d = acc_q + prod_ext;
        case (state_q)
            IDLE: begin
                if (increment_threshold && !decrement_threshold)
                    thr_d = (thr_up > MAX_W) ? MAX_W[SCORE_WIDTH-1:0] : thr_up[SCORE_WIDTH-1:0];
                else if (decrement_threshold && !increment_threshold)
                    thr_d = (thr_dn < MIN_W) ? MIN_W[SCORE_WIDTH-1:0] : thr_dn[SCORE_WIDTH-1:0];
                if (start) begin
                    cfg_addr_d   = cfg_addr;
                    cfg_weight_d = cfg_weight;
                    base_d       = base_addr;
                    n_d          = n_start;
                    idx_d        = CNT_WIDTH'(1);
                    acc_d        = '0;
                    busy_d       = 1'b1;
                    if (n_start != '0) begin
                        rd_addr_d  = base_addr + cfg_addr[ADDR_WIDTH-1:0];
                        rd_valid_d = 1'b1;
                        rd_wt_d    = cfg_weight[2:0];
                    end
                end
            end
            ISSUE: begin
                rd_addr_d  = base_q + off_tab[idx_q[IDX_W-1:0]];
                rd_valid_d = 1'b1;
                rd_wt_d    = wt_tab[idx_q[IDX_W-1:0]];
                idx_d      = idx_q + CNT_WIDTH'(1);
            end
            COMPARE: begin
                score_d = acc_q;
                flag_d  = acc_q > thr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q         <= 1'b0;
            cfg_addr_q   <= '0;
            cfg_weight_q <= '0;
            base_q       <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_wt_q      <= '0;
            pipe_v_q     <= '0;
            pipe_w_q     <= '{default: '0};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            flag_q       <= 1'b0;
            score_q      <= '0;
            thr_q        <= SCORE_WIDTH'(THR_INIT);
        end else begin
            en_q         <= detect_en;
            cfg_addr_q   <= cfg_addr_d;
            cfg_weight_q <= cfg_weight_d;
            base_q       <= base_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            rd_addr_q    <= rd_addr_d;
            rd_valid_q   <= rd_valid_d;
            rd_wt_q      <= rd_wt_d;
            pipe_v_q     <= pipe_v_d;
            pipe_w_q     <= pipe_w_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            flag_q       <= flag_d;
            score_q      <= score_d;
            thr_q        <= thr_d;
        end
    end

    assign rd_addr       = rd_addr_q;
    assign busy          = busy_q;
    assign detect_done   = done_q;
    assign detected_flag = flag_q;
    assign score         = score_q;
    assign threshold     = thr_q;

endmodule
